tube_scan_driver: RTL
=====================

Name: tube_scan_driver

Overview:
Upstream stage of the 7-segment tube controller. Holds a CPU-writable 16-bit display value, 4 decimal-point bits and a control byte, and time-multiplexes the four digits. Drives the controller's digit select, the four nibbles and the dots, plus a blank strobe that the top level ANDs into tubeDig for anti-ghosting and leading-zero suppression. Display data is double-buffered and committed only at frame boundaries, so the display never tears.

Parameters:
CLK_DIV, 50000, clock cycles per digit slot; constraint CLK_DIV >= 2.
BLANK_CYCLES, 500, cycles at the start of each slot with blank forced high; constraint 0 <= BLANK_CYCLES < CLK_DIV.

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  reset, asynchronous, active-high
we  in  1  register write strobe, one write per cycle
addr  in  2  write address: 0 = value[7:0], 1 = value[15:8], 2 = dots (wdata[3:0]), 3 = control
wdata  in  8  write data
dig  out  2  current digit index, to the controller's dig input
dig1  out  4  committed value[3:0], rightmost digit, shown at dig=0
dig2  out  4  committed value[7:4]
dig3  out  4  committed value[11:8]
dig4  out  4  committed value[15:12], leftmost digit
dots  out  4  committed decimal points; bit i is shown at dig=i
blank  out  1  1 = current digit must be dark
frameTick  out  1  one-cycle pulse on each frame commit

Behaviour:
- Interface: one clock, clk. rst is asynchronous and active-high.
- Reset values: shadow and committed value = 0, shadow and committed dots = 0, control = 0 (enable=0, lzb=0), cnt = 0, dig = 0, frameTick = 0, blank = 1.
- Control byte: bit0 = enable, bit1 = lzb (leading-zero blank), bits 7:2 ignored. Control is not shadowed; a write takes effect the next cycle.
- Writes to addr 0–2 update the shadow registers only. Each write lands 1 cycle after the we edge.
- Prescaler: cnt runs 0..CLK_DIV-1 and is $clog2(CLK_DIV) bits wide. At cnt = CLK_DIV-1: cnt goes to 0 and dig increments modulo 4 (3 wraps to 0).
- Frame commit: when dig = 3 and cnt = CLK_DIV-1, the committed value and dots load from the shadow, and frameTick = 1 on the following cycle.
  - A write in the commit cycle bypasses into the commit: the committed register takes the newly written byte.
- While enable = 0: cnt and dig are held at 0, frameTick = 0, and the committed registers track the shadow every cycle.
- Enable rising: scanning starts from dig = 0, cnt = 0 with the current shadow contents. The first frameTick arrives 4*CLK_DIV cycles after enable is first seen high.
- Enable falling mid-frame: cnt and dig return to 0 on the next cycle, and no frameTick is issued.
- blank = !enable | (cnt < BLANK_CYCLES) | (lzb & leadingZero[dig]).
  - leadingZero[3] = (dig4 == 0).
  - leadingZero[2] = leadingZero[3] & (dig3 == 0).
  - leadingZero[1] = leadingZero[2] & (dig2 == 0).
  - leadingZero[0] = 0, so the rightmost digit is never suppressed.
  - leadingZero is computed from committed values only.
  - With BLANK_CYCLES = 0 the window term is 0.
- blank, dig, dig1–dig4 and dots are derived from registered state only. There is no combinational path from we/addr/wdata to any output.
- Reset asserted mid-frame: all state returns immediately to reset values, and shadow contents are lost.

Decomposition:
- Shared package tube_pkg holds:
  - address constants ADDR_VAL_LO = 0, ADDR_VAL_HI = 1, ADDR_DOTS = 2, ADDR_CTRL = 3;
  - control bit indices CTRL_EN = 0, CTRL_LZB = 1.
- One sub-module, tube_prescaler. It owns cnt, the enable hold/clear, the slot-end pulse (cnt = CLK_DIV-1) and the blank-window flag (cnt < BLANK_CYCLES).
- The top level keeps the register file, dig, the commit and leading-zero logic.

Test Plan:
- Reset, then enable with CLK_DIV=8, BLANK_CYCLES=2, value=16'h1234 -> dig sequence 0,1,2,3 with each digit held 8 cycles; dig1..dig4 = 4,3,2,1; blank high for 2 cycles at the start of every slot; frameTick at cycle 32 after enable.
- Write value lo=8'hCD while dig=1 -> dig1/dig2 are unchanged until the commit, then read D/C in the cycle after frameTick; no partial update is visible.
- Write addr 0 in the exact commit cycle with 8'h5A -> the committed value immediately holds 5A; the following frame shows dig1=A, dig2=5.
- lzb=1, value=16'h0040 -> blank held high for the whole of slots dig=3 and dig=2, low outside the window for dig=1 and dig=0; value=0 -> only dig=0 is unblanked.
- dots=4'b0101 via addr 2 -> the committed dots = 0101 only after the next frameTick.
- Clear enable at dig=2, cnt=5 -> the next cycle shows dig=0, cnt=0, blank=1 and no frameTick. Assert rst mid-scan -> all outputs at reset values asynchronously, without waiting for a clk edge.

Source files
------------

// File: rtl/tube_pkg.sv
// tube_pkg: shared constants for the tube scan driver.
//   Register map addresses for the write port and control-byte bit positions.
package tube_pkg;

    localparam logic [1:0] ADDR_VAL_LO = 2'd0;
    localparam logic [1:0] ADDR_VAL_HI = 2'd1;
    localparam logic [1:0] ADDR_DOTS   = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_LZB = 1;

endpackage

// File: rtl/tube_prescaler.sv
// tube_prescaler: per-digit slot timer for the tube scan driver.
//   clk, rst    : clock, asynchronous active-high reset
//   enable      : scanning enable; while low the counter is held at 0
//   slot_end    : high in the last cycle of a slot (cnt = CLK_DIV-1) while enabled
//   in_window   : high during the first BLANK_CYCLES cycles of a slot
module tube_prescaler #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic slot_end,
    output logic in_window
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!enable || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign slot_end = enable && (cnt == CNT_LAST);

    // A zero-length window would be an always-false unsigned compare.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_window
            assign in_window = 1'b0;
        end else begin : g_window
            assign in_window = (cnt < CW'(BLANK_CYCLES));
        end
    endgenerate

endmodule

// File: rtl/tube_scan_driver.sv
// tube_scan_driver: register file, digit multiplexing and frame commit for
// the 7-segment tube controller.
//   clk, rst          : clock, asynchronous active-high reset
//   we, addr, wdata   : CPU write port (0/1 value bytes, 2 dots, 3 control)
//   dig               : current digit index
//   dig1..dig4        : committed value nibbles, dig1 rightmost
//   dots              : committed decimal points
//   blank             : current digit must be dark
//   frameTick         : one-cycle pulse after each frame commit
module tube_scan_driver
    import tube_pkg::*;
#(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    output logic [1:0] dig,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic [3:0] dig4,
    output logic [3:0] dots,
    output logic       blank,
    output logic       frameTick
);

    logic [15:0] val_sh, val_cm, val_nx;
    logic [3:0]  dots_sh, dots_cm, dots_nx;
    logic        en, lzb;
    logic [1:0]  dig_q;
    logic        tick_q;
    logic        slot_end, in_window, commit;
    logic [3:0]  lead_zero;

    tube_prescaler #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .enable    (en),
        .slot_end  (slot_end),
        .in_window (in_window)
    );

    // Shadow contents including this cycle's write, so a write landing in the
    // commit cycle is carried straight into the committed registers.
    assign val_nx[7:0]  = (we && addr == ADDR_VAL_LO) ? wdata : val_sh[7:0];
    assign val_nx[15:8] = (we && addr == ADDR_VAL_HI) ? wdata : val_sh[15:8];
    assign dots_nx      = (we && addr == ADDR_DOTS) ? wdata[3:0] : dots_sh;

    assign commit = slot_end && (dig_q == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_sh  <= '0;
            val_cm  <= '0;
            dots_sh <= '0;
            dots_cm <= '0;
            en      <= 1'b0;
            lzb     <= 1'b0;
            dig_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            val_sh  <= val_nx;
            dots_sh <= dots_nx;
            if (we && addr == ADDR_CTRL) begin
                en  <= wdata[CTRL_EN];
                lzb <= wdata[CTRL_LZB];
            end
            // Idle display follows the shadow; a running one only at frame end.
            if (!en || commit) begin
                val_cm  <= val_nx;
                dots_cm <= dots_nx;
            end
            tick_q <= commit;
            if (!en) begin
                dig_q <= '0;
            end else if (slot_end) begin
                dig_q <= dig_q + 2'd1;
            end
        end
    end

    assign lead_zero[3] = (val_cm[15:12] == 4'h0);
    assign lead_zero[2] = lead_zero[3] && (val_cm[11:8] == 4'h0);
    assign lead_zero[1] = lead_zero[2] && (val_cm[7:4] == 4'h0);
    assign lead_zero[0] = 1'b0;

    assign dig       = dig_q;
    assign dig1      = val_cm[3:0];
    assign dig2      = val_cm[7:4];
    assign dig3      = val_cm[11:8];
    assign dig4      = val_cm[15:12];
    assign dots      = dots_cm;
    assign frameTick = tick_q;
    assign blank     = !en || in_window || (lzb && lead_zero[dig_q]);

endmodule
